// File: rtl/product_acc_pkg.sv
// Shared types and sizing for the product accumulator that sits behind the
// 8x8 radix-4 Booth multiplier.
package product_acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int COUNT_W    = 8;
    localparam int COUNT_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/product_acc_sat_add.sv
// Combinational (ACC_W+1)-bit adder of a sign-extended product onto the
// accumulator, with optional clamping and an overflow flag.
module sat_add #(
    parameter int PROD_W   = 16,
    parameter int ACC_W    = 24,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W:0] wideAcc;
    logic [ACC_W:0] wideProd;
    logic [ACC_W:0] wideSum;

    assign wideAcc  = {acc_i[ACC_W-1], acc_i};
    assign wideProd = {{(ACC_W+1-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    assign wideSum  = wideAcc + wideProd;

    // The two top bits disagree only when the true sum left the ACC_W range.
    assign ovf_o = wideSum[ACC_W] ^ wideSum[ACC_W-1];

    // Bit ACC_W carries the true sign, so it picks which rail to clamp to.
    always_comb begin
        sum_o = wideSum[ACC_W-1:0];
        if (ovf_o && (SATURATE != 0)) begin
            if (wideSum[ACC_W]) begin
                sum_o = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum_o = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/product_acc.sv
// Group accumulator: sums a stream of signed products, then presents the
// group sum, term count and sticky overflow on a valid/ready output.
module product_acc
    import product_acc_pkg::*;
#(
    parameter int PROD_W   = PROD_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_product,
    input  logic               in_last,
    input  logic               acc_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_overflow,
    output logic [COUNT_W-1:0] out_count
);

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_W-1:0]     outSum_q, outSum_d;
    logic [COUNT_W-1:0]   outCount_q, outCount_d;
    logic                 outOvf_q, outOvf_d;

    logic                 inFire;
    logic                 outFire;
    logic [ACC_W-1:0]     prodExt;
    logic [ACC_W-1:0]     addSum;
    logic                 addOvf;
    logic [COUNT_W-1:0]   countInc;

    assign in_ready  = (state_q != HOLD) && !acc_clear;
    assign out_valid = (state_q == HOLD);
    assign inFire    = in_valid && in_ready;
    assign outFire   = out_valid && out_ready;

    assign prodExt  = {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
    assign countInc = (count_q == COUNT_W'(COUNT_MAX)) ? count_q : count_q + COUNT_W'(1);

    sat_add #(
        .PROD_W   (PROD_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .acc_i  (acc_q),
        .prod_i (in_product),
        .sum_o  (addSum),
        .ovf_o  (addOvf)
    );

    // Output registers are loaded only on HOLD entry so they stay frozen
    // while the group result waits for the downstream handshake.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        outSum_d   = outSum_q;
        outCount_d = outCount_q;
        outOvf_d   = outOvf_q;

        if (acc_clear) begin
            state_d    = IDLE;
            acc_d      = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            outSum_d   = '0;
            outCount_d = '0;
            outOvf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (inFire) begin
                        acc_d   = prodExt;
                        count_d = COUNT_W'(1);
                        ovf_d   = 1'b0;
                        if (in_last) begin
                            state_d    = HOLD;
                            outSum_d   = prodExt;
                            outCount_d = COUNT_W'(1);
                            outOvf_d   = 1'b0;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (inFire) begin
                        acc_d   = addSum;
                        count_d = countInc;
                        ovf_d   = ovf_q | addOvf;
                        if (in_last) begin
                            state_d    = HOLD;
                            outSum_d   = addSum;
                            outCount_d = countInc;
                            outOvf_d   = ovf_q | addOvf;
                        end
                    end
                end
                HOLD: begin
                    if (outFire) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            outSum_q   <= '0;
            outCount_q <= '0;
            outOvf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            outSum_q   <= outSum_d;
            outCount_q <= outCount_d;
            outOvf_q   <= outOvf_d;
        end
    end

    assign out_sum      = outSum_q;
    assign out_count    = outCount_q;
    assign out_overflow = outOvf_q;

endmodule

// File: tb/tb_product_acc.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus
// and are compared against a whole-group arithmetic model.
module tb_product_acc;

    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;
    localparam longint SPAN = 64'sd16777216;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        acc_clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        readySat, validSat, ovfSat;
    logic [23:0] sumSat;
    logic [7:0]  countSat;
    logic        readyWrap, validWrap, ovfWrap;
    logic [23:0] sumWrap;
    logic [7:0]  countWrap;

    int checks = 0;
    int failures = 0;

    logic [15:0] grp[$];
    logic [23:0] expSumSat, expSumWrap;
    logic        expOvfSat, expOvfWrap;
    logic [7:0]  expCount;

    always #5 clk = ~clk;

    product_acc #(.PROD_W(16), .ACC_W(24), .SATURATE(1)) dutSat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(readySat),
        .in_product(in_product), .in_last(in_last), .acc_clear(acc_clear),
        .out_valid(validSat), .out_ready(out_ready), .out_sum(sumSat),
        .out_overflow(ovfSat), .out_count(countSat)
    );

    product_acc #(.PROD_W(16), .ACC_W(24), .SATURATE(0)) dutWrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(readyWrap),
        .in_product(in_product), .in_last(in_last), .acc_clear(acc_clear),
        .out_valid(validWrap), .out_ready(out_ready), .out_sum(sumWrap),
        .out_overflow(ovfWrap), .out_count(countWrap)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Whole-group model: plain integer sums, clamped or wrapped to 24 bits.
    task automatic computeExpected();
        longint accS = 0;
        longint accW = 0;
        longint p;
        logic signed [15:0] ps;
        expOvfSat = 1'b0;
        expOvfWrap = 1'b0;
        for (int i = 0; i < grp.size(); i++) begin
            ps = grp[i];
            p = longint'(ps);
            accS = accS + p;
            if (accS > MAXV) begin accS = MAXV; expOvfSat = 1'b1; end
            if (accS < MINV) begin accS = MINV; expOvfSat = 1'b1; end
            accW = accW + p;
            if (accW > MAXV) begin accW = accW - SPAN; expOvfWrap = 1'b1; end
            if (accW < MINV) begin accW = accW + SPAN; expOvfWrap = 1'b1; end
        end
        expSumSat  = 24'(accS);
        expSumWrap = 24'(accW);
        expCount   = (grp.size() > 255) ? 8'd255 : 8'(grp.size());
    endtask

    task automatic sendGroup(input bit closeGroup);
        for (int i = 0; i < grp.size(); i++) begin
            in_valid   = 1'b1;
            in_product = grp[i];
            in_last    = closeGroup && (i == grp.size() - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic applyStimulusReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        applyStimulusReset();
        checks++;
        if (validSat !== 1'b0 || validWrap !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_valid: got %b/%b want 0", validSat, validWrap);
        end
        checks++;
        if (sumSat !== 24'h0 || countSat !== 8'd0 || ovfSat !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_outs: sum %h count %0d ovf %b want 0", sumSat, countSat, ovfSat);
        end
        checks++;
        if (readySat !== 1'b1 || readyWrap !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_ready: got %b/%b want 1", readySat, readyWrap);
        end
    endtask

    task automatic test_single();
        grp = '{16'h0064};
        computeExpected();
        sendGroup(1'b1);
        checks++;
        if (validSat !== 1'b1 || validWrap !== 1'b1) begin
            failures++; $display("[TB] FAIL single_valid: got %b/%b want 1", validSat, validWrap);
        end
        checks++;
        if (sumSat !== 24'd100 || countSat !== 8'd1 || ovfSat !== 1'b0) begin
            failures++; $display("[TB] FAIL single_result: sum %0d count %0d ovf %b want 100 1 0", sumSat, countSat, ovfSat);
        end
        checks++;
        if (sumSat !== expSumSat || sumWrap !== expSumWrap) begin
            failures++; $display("[TB] FAIL single_model: got %h/%h want %h/%h", sumSat, sumWrap, expSumSat, expSumWrap);
        end
        drain();
    endtask

    task automatic test_three();
        grp = '{16'h7FFF, 16'h8000, 16'hFFFE};
        sendGroup(1'b1);
        checks++;
        if (sumSat !== 24'hFFFFFD || sumWrap !== 24'hFFFFFD) begin
            failures++; $display("[TB] FAIL three_sum: got %h/%h want fffffd", sumSat, sumWrap);
        end
        checks++;
        if (countSat !== 8'd3 || countWrap !== 8'd3 || ovfSat !== 1'b0) begin
            failures++; $display("[TB] FAIL three_count: got %0d/%0d ovf %b want 3 3 0", countSat, countWrap, ovfSat);
        end
        drain();
    endtask

    task automatic test_long_saturation();
        grp.delete();
        for (int i = 0; i < 256; i++) grp.push_back(16'h8000);
        sendGroup(1'b1);
        checks++;
        if (sumSat !== 24'h800000 || sumWrap !== 24'h800000 || ovfSat !== 1'b0 || ovfWrap !== 1'b0) begin
            failures++; $display("[TB] FAIL n256_sum: got %h/%h ovf %b/%b want 800000 no ovf", sumSat, sumWrap, ovfSat, ovfWrap);
        end
        checks++;
        if (countSat !== 8'd255) begin
            failures++; $display("[TB] FAIL n256_count: got %0d want 255", countSat);
        end
        drain();
        grp.push_back(16'h8000);
        sendGroup(1'b1);
        checks++;
        if (sumSat !== 24'h800000 || ovfSat !== 1'b1) begin
            failures++; $display("[TB] FAIL n257_sat: got %h ovf %b want 800000 1", sumSat, ovfSat);
        end
        checks++;
        if (sumWrap !== 24'h7F8000 || ovfWrap !== 1'b1) begin
            failures++; $display("[TB] FAIL n257_wrap: got %h ovf %b want 7f8000 1", sumWrap, ovfWrap);
        end
        checks++;
        if (countSat !== 8'd255 || countWrap !== 8'd255) begin
            failures++; $display("[TB] FAIL n257_count: got %0d/%0d want 255", countSat, countWrap);
        end
        drain();
    endtask

    task automatic test_backpressure();
        grp = '{16'd1000, 16'hFC18, 16'd42};
        computeExpected();
        sendGroup(1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_product = 16'd9;
            #1;
            checks++;
            if (readySat !== 1'b0 || validSat !== 1'b1 || sumSat !== expSumSat || countSat !== expCount) begin
                failures++; $display("[TB] FAIL stall_%0d: ready %b valid %b sum %h count %0d want 0 1 %h %0d",
                                     i, readySat, validSat, sumSat, countSat, expSumSat, expCount);
            end
            step();
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (validSat !== 1'b0 || readySat !== 1'b1) begin
            failures++; $display("[TB] FAIL release: valid %b ready %b want 0 1", validSat, readySat);
        end
        grp = '{16'd5};
        sendGroup(1'b1);
        checks++;
        if (sumSat !== 24'd5 || countSat !== 8'd1) begin
            failures++; $display("[TB] FAIL fresh_group: sum %0d count %0d want 5 1", sumSat, countSat);
        end
        drain();
    endtask

    task automatic test_clear();
        grp = '{16'd10, 16'd20};
        sendGroup(1'b0);
        in_valid = 1'b1;
        in_product = 16'd99;
        in_last = 1'b1;
        acc_clear = 1'b1;
        #1;
        checks++;
        if (readySat !== 1'b0 || readyWrap !== 1'b0) begin
            failures++; $display("[TB] FAIL clear_ready: got %b/%b want 0", readySat, readyWrap);
        end
        step();
        acc_clear = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (validSat !== 1'b0 || countSat !== 8'd0 || sumSat !== 24'h0) begin
            failures++; $display("[TB] FAIL clear_mid: valid %b count %0d sum %h want 0 0 0", validSat, countSat, sumSat);
        end
        grp = '{16'd7};
        sendGroup(1'b1);
        checks++;
        if (sumSat !== 24'd7 || countSat !== 8'd1) begin
            failures++; $display("[TB] FAIL clear_restart: sum %0d count %0d want 7 1", sumSat, countSat);
        end
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        checks++;
        if (validSat !== 1'b0 || sumSat !== 24'h0 || countSat !== 8'd0) begin
            failures++; $display("[TB] FAIL clear_hold: valid %b sum %h count %0d want 0 0 0", validSat, sumSat, countSat);
        end
    endtask

    task automatic test_rst_override();
        grp = '{16'd300, 16'd400};
        sendGroup(1'b0);
        rst = 1'b1; acc_clear = 1'b1; in_valid = 1'b1; in_product = 16'd11;
        step();
        rst = 1'b0; acc_clear = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (validSat !== 1'b0 || sumSat !== 24'h0 || countSat !== 8'd0 || ovfSat !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_mid: valid %b sum %h count %0d ovf %b want 0", validSat, sumSat, countSat, ovfSat);
        end
        grp = '{16'd123};
        sendGroup(1'b1);
        rst = 1'b1; acc_clear = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (validSat !== 1'b0 || sumSat !== 24'h0 || countSat !== 8'd0 || readySat !== 1'b1) begin
            failures++; $display("[TB] FAIL rst_hold: valid %b sum %h count %0d ready %b want 0 0 0 1", validSat, sumSat, countSat, readySat);
        end
        grp = '{16'd3};
        sendGroup(1'b1);
        checks++;
        if (sumSat !== 24'd3 || countSat !== 8'd1) begin
            failures++; $display("[TB] FAIL rst_restart: sum %0d count %0d want 3 1", sumSat, countSat);
        end
        drain();
    endtask

    task automatic test_random();
        for (int g = 0; g < 12; g++) begin
            int n = int'($urandom_range(1, 8));
            int stall = int'($urandom_range(0, 3));
            grp.delete();
            for (int i = 0; i < n; i++) grp.push_back(16'($urandom));
            computeExpected();
            sendGroup(1'b1);
            checks++;
            if (validSat !== 1'b1 || sumSat !== expSumSat || sumWrap !== expSumWrap) begin
                failures++; $display("[TB] FAIL rand_sum_%0d: valid %b sum %h/%h want 1 %h/%h",
                                     g, validSat, sumSat, sumWrap, expSumSat, expSumWrap);
            end
            checks++;
            if (countSat !== expCount || ovfSat !== expOvfSat || ovfWrap !== expOvfWrap) begin
                failures++; $display("[TB] FAIL rand_meta_%0d: count %0d ovf %b/%b want %0d %b/%b",
                                     g, countSat, ovfSat, ovfWrap, expCount, expOvfSat, expOvfWrap);
            end
            for (int s = 0; s < stall; s++) step();
            drain();
            checks++;
            if (validSat !== 1'b0 || validWrap !== 1'b0) begin
                failures++; $display("[TB] FAIL rand_drain_%0d: valid %b/%b want 0", g, validSat, validWrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_long_saturation();
        test_backpressure();
        test_clear();
        test_rst_override();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
